addac_ctrl: RTL and testbench

Parallel-to-serial controller that drives the bit-serial adder/accumulator cell (`addac`) from its operand side and reassembles its serial sum. It accepts two WIDTH-bit operands, shifts them LSB-first into the cell one bit per strobe, and captures the returned sum bit and carry. It presents a parallel result with a one-cycle `done` pulse. It sits between the register-level datapath and the `addac` serial cell.

---
 rtl/addac_pkg.sv | 14 +
 rtl/addac_shreg.sv | 26 ++
 rtl/addac_ctrl.sv | 146 ++++++++++++++
 tb/tb_addac_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/addac_pkg.sv
// Shared types and defaults for the addac serial-cell controller.
package addac_pkg;

  localparam int ADDAC_DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRIVE,
    PULSE,
    DONE
  } addac_state_t;

endpackage

// File: rtl/addac_shreg.sv
// Right-shift register with parallel load, serial input at the MSB and shift enable.
module addac_shreg
  import addac_pkg::*;
#(
  parameter int WIDTH = ADDAC_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/addac_ctrl.sv
// Parallel-to-serial controller for the addac bit-serial adder cell.
// Define ADDAC_SUB_EN to add the subtract mode (sub input, ser_cset output).
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | clearing (or presetting) the cell carry
// DRIVE | presenting the current operand bits
// PULSE | strobing the cell; sum bit captured at the end
// DONE  | result valid, done pulse
module addac_ctrl
  import addac_pkg::*;
#(
  parameter int WIDTH = ADDAC_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef ADDAC_SUB_EN
  input  logic             sub,
  output logic             ser_cset,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_clr,
  output logic             ser_stb,
  input  logic             ser_s,
  input  logic             ser_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  addac_state_t     state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             accept, ab_shift, res_shift, last;
  logic             sub_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             unused_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ab_shift  = 1'b0;
    res_shift = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: state_nxt = DRIVE;
      // Operand regs advance here; ser_a/ser_b keep the bit through PULSE.
      DRIVE: begin
        ab_shift  = 1'b1;
        state_nxt = PULSE;
      end
      PULSE: begin
        res_shift = 1'b1;
        last      = (cnt == CW'(WIDTH - 1));
        state_nxt = last ? DONE : DRIVE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           cnt <= '0;
    else if (accept)    cnt <= '0;
    else if (res_shift) cnt <= cnt + CW'(1);
  end

`ifdef ADDAC_SUB_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ser_cset <= 1'b0;
    else      ser_cset <= (state_nxt == CLEAR) && sub;
  end
`else
  assign sub_q = 1'b0;
`endif

  addac_shreg #(.WIDTH(WIDTH)) u_sh_a (
    .clk(clk), .rst(rst), .load(accept), .load_val(op_a),
    .shift(ab_shift), .sin(1'b0), .q(a_q)
  );

  addac_shreg #(.WIDTH(WIDTH)) u_sh_b (
    .clk(clk), .rst(rst), .load(accept), .load_val(op_b),
    .shift(ab_shift), .sin(1'b0), .q(b_q)
  );

  addac_shreg #(.WIDTH(WIDTH)) u_sh_res (
    .clk(clk), .rst(rst), .load(accept), .load_val('0),
    .shift(res_shift), .sin(ser_s), .q(res_q)
  );

  // Only the operand LSBs are observed; the result LSB is the reload value shifted out.
  assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], res_q[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      ser_clr <= 1'b0;
      ser_stb <= 1'b0;
      ser_a   <= 1'b0;
      ser_b   <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
    end else begin
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      ser_clr <= (state_nxt == CLEAR);
      ser_stb <= (state_nxt == PULSE);
      if (state_nxt == DRIVE) begin
        ser_a <= a_q[0];
        ser_b <= b_q[0] ^ sub_q;
      end else if (state_nxt != PULSE) begin
        ser_a <= 1'b0;
        ser_b <= 1'b0;
      end
      if (last) begin
        result <= {ser_s, res_q[WIDTH-1:1]};
        carry  <= ser_cout;
      end
    end
  end

endmodule

// File: tb/tb_addac_ctrl.sv
// Self-checking bench for addac_ctrl with a behavioural model of the serial cell.
module tb_addac_ctrl;

  localparam int W    = 8;
  localparam int TEND = 2 * W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub_in = 1'b0;
  logic         ser_cset;
  logic         busy, done, carry, ser_a, ser_b, ser_clr, ser_stb, ser_s, ser_cout;
  logic [W-1:0] result;

  addac_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
`ifdef ADDAC_SUB_EN
    .sub(sub_in), .ser_cset(ser_cset),
`endif
    .busy(busy), .done(done), .result(result), .carry(carry),
    .ser_a(ser_a), .ser_b(ser_b), .ser_clr(ser_clr), .ser_stb(ser_stb),
    .ser_s(ser_s), .ser_cout(ser_cout)
  );

`ifndef ADDAC_SUB_EN
  assign ser_cset = 1'b0;
`endif

  always #5 clk = ~clk;

  // serial adder cell
  logic cc;
  assign ser_s    = ser_a ^ ser_b ^ cc;
  assign ser_cout = (ser_a & ser_b) | (ser_a & cc) | (ser_b & cc);
  always @(posedge clk or negedge rst) begin
    if (!rst)         cc <= 1'b0;
    else if (ser_clr) cc <= ser_cset;
    else if (ser_stb) cc <= ser_cout;
  end

  int npass = 0;
  int ntotal = 0;
  int cyc = 0;
  int stb_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: t = cycles since the accepted start (0 = idle).
  int           t;
  logic [W-1:0] ma, mb, mres;
  logic         msub, mcarry;

  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    int unsigned v;
    if (s) v = int'(a) + int'((~b) & {W{1'b1}}) + 1;
    else   v = int'(a) + int'(b);
    return v[W:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t      <= 0;
      mres   <= '0;
      mcarry <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      msub   <= 1'b0;
    end else if (t == 0) begin
      if (start) begin
        t    <= 1;
        ma   <= op_a;
        mb   <= op_b;
        msub <= sub_in;
      end
    end else if (t == TEND) begin
      t <= 0;
    end else begin
      t <= t + 1;
      if (t + 1 == TEND) begin
        mres   <= model_sum(ma, mb, msub)[W-1:0];
        mcarry <= model_sum(ma, mb, msub)[W];
      end
    end
  end

  // Per-cycle compare against the model.
  int   e_bit;
  logic e_in, e_pulse, e_a, e_b;
  always @(negedge clk) begin
    if (rst) begin
      e_in    = (t >= 2) && (t <= 2 * W + 1);
      e_bit   = e_in ? (t - 2) / 2 : 0;
      e_pulse = e_in && (((t - 2) % 2) == 1);
      e_a     = e_in ? ma[e_bit] : 1'b0;
      e_b     = e_in ? (mb[e_bit] ^ msub) : 1'b0;
      check("busy",     busy,     (t != 0));
      check("done",     done,     (t == TEND));
      check("ser_clr",  ser_clr,  (t == 1));
      check("ser_stb",  ser_stb,  e_pulse);
      check("ser_a",    ser_a,    e_a);
      check("ser_b",    ser_b,    e_b);
      check("result",   result,   mres);
      check("carry",    carry,    mcarry);
      check("ser_cset", ser_cset, (t == 1) && msub);
      if (ser_stb) stb_cnt++;
    end
  end

  int acc_cyc, lat, d1, d2;

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    sub_in = s;
    @(negedge clk);
    start   = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy",   busy,    1'b0);
    check("rst_done",   done,    1'b0);
    check("rst_stb",    ser_stb, 1'b0);
    check("rst_clr",    ser_clr, 1'b0);
    check("rst_result", result,  8'h00);
    check("rst_carry",  carry,   1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic add, latency and strobe count
    stb_cnt = 0;
    start_op(8'h35, 8'h4A, 1'b0);
    wait_done(d1);
    check("latency", d1 - acc_cyc, 17);
    check("lit_7f_result", result, 8'h7F);
    check("lit_7f_carry",  carry,  1'b0);
    @(negedge clk);
    check("stb_count", stb_cnt, 8);

    // overflow wraps, carry out
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(d1);
    check("lit_ff01_result", result, 8'h00);
    check("lit_ff01_carry",  carry,  1'b1);

    // start while busy is ignored
    start_op(8'h11, 8'h22, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; op_a = 8'hAA; op_b = 8'h77;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1; op_a = 8'hF0; op_b = 8'hF0;
    @(negedge clk);
    start = 1'b0;
    wait_done(d1);
    check("lit_ignore_result", result, 8'h33);
    check("lit_ignore_carry",  carry,  1'b0);

    // asynchronous abort mid-operation
    start_op(8'h35, 8'h4A, 1'b0);
    repeat (6) @(negedge clk);
    check("stb_before_rst", ser_stb, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_stb",    ser_stb, 1'b0);
    check("abort_busy",   busy,    1'b0);
    check("abort_result", result,  8'h00);
    @(negedge clk);
    rst = 1'b1;
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(d1);
    check("lit_46_result", result, 8'h46);
    check("lit_46_carry",  carry,  1'b0);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; op_a = 8'h0F; op_b = 8'h01; sub_in = 1'b0;
    wait_done(d1);
    @(negedge clk);
    wait_done(d2);
    start = 1'b0;
    check("b2b_period", d2 - d1, 19);
    check("lit_b2b_result", result, 8'h10);

`ifdef ADDAC_SUB_EN
    repeat (3) @(negedge clk);
    start_op(8'h50, 8'h20, 1'b1);
    wait_done(d1);
    check("lit_sub30_result", result, 8'h30);
    check("lit_sub30_carry",  carry,  1'b1);
    @(negedge clk);
    start_op(8'h20, 8'h50, 1'b1);
    wait_done(d1);
    check("lit_subd0_result", result, 8'hD0);
    check("lit_subd0_carry",  carry,  1'b0);
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
